// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
// - fifo_addr_w(): derives the entry index width from the depth.
// - FIFO_MODE_*: read-data mode encodings for the SHOW_AHEAD parameter.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_SHOW_AHEAD = 1;
  localparam int unsigned FIFO_MODE_REGISTERED = 0;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle for sync_fifo_prog.
// Parameters: DATA_W (word width), ADDR_W (entry index width; counts are ADDR_W+1 bits).
// Modports:
//   master - producer/consumer side (drives data_i, wr_i, rd_i, thresholds, err_clr_i[, flush_i])
//   slave  - FIFO side (drives data_o, level_o and all status flags)
// Optional: flush_i exists only when FIFO_FLUSH_EN is defined.
interface sync_fifo_prog_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);

  logic [DATA_W-1:0] data_i;
  logic              wr_i;
  logic              rd_i;
  logic [ADDR_W:0]   afull_thr_i;
  logic [ADDR_W:0]   aempty_thr_i;
  logic              err_clr_i;
`ifdef FIFO_FLUSH_EN
  logic              flush_i;
`endif
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W:0]   level_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
`ifdef FIFO_FLUSH_EN
    output flush_i,
`endif
    output data_i, wr_i, rd_i, afull_thr_i, aempty_thr_i, err_clr_i,
    input  data_o, level_o, full_o, empty_o, almost_full_o, almost_empty_o,
    input  overflow_o, underflow_o
  );

  modport slave (
`ifdef FIFO_FLUSH_EN
    input  flush_i,
`endif
    input  data_i, wr_i, rd_i, afull_thr_i, aempty_thr_i, err_clr_i,
    output data_o, level_o, full_o, empty_o, almost_full_o, almost_empty_o,
    output overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and occupancy control for sync_fifo_prog.
// Qualifies write/read requests against the registered full/empty state and keeps
// ADDR_W+1 bit pointers (MSB = wrap bit) plus a registered level counter.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             synchronous flush (only with FIFO_FLUSH_EN)
//   wr_i, rd_i          raw requests
//   we_o, re_o          accepted write / read this cycle
//   wptr_o, rptr_o      write / read pointers
//   level_o             occupancy 0..DEPTH
//   full_o, empty_o     level_o == DEPTH / level_o == 0
// Optional: FIFO_FLUSH_EN adds flush_i.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FIFO_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            wr_i,
  input  logic            rd_i,
  output logic            we_o,
  output logic            re_o,
  output logic [ADDR_W:0] wptr_o,
  output logic [ADDR_W:0] rptr_o,
  output logic [ADDR_W:0] level_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam logic [ADDR_W:0] DepthVal = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            flush;

`ifdef FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign full_o  = (level_q == DepthVal);
  assign empty_o = (level_q == '0);

  // Acceptance looks only at registered state: a same-cycle read never frees
  // room for a write, and a same-cycle write never feeds a read.
  assign we_o = wr_i & ~full_o & ~flush;
  assign re_o = rd_i & ~empty_o & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (we_o) wptr_d = wptr_q + 1'b1;
      if (re_o) rptr_d = rptr_q + 1'b1;
      case ({we_o, re_o})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign level_o = level_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Programmable single-clock FIFO between the bit-plane encoder and the packer.
// Holds the storage array, read-data path, threshold comparators and sticky error flags;
// pointer/level bookkeeping lives in fifo_ptr_ctrl.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          sync_fifo_prog_if.slave: data_i/wr_i/rd_i, thresholds, err_clr_i,
//                [flush_i], data_o, level_o, full/empty, almost flags, overflow/underflow
// Parameters: DATA_W, DEPTH (power of 2, >= 4), SHOW_AHEAD (1 = head shown, 0 = registered).
// Optional: define FIFO_FLUSH_EN for the synchronous flush_i input.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned SHOW_AHEAD = FIFO_MODE_SHOW_AHEAD
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);

  logic              we;
  logic              re;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef FIFO_FLUSH_EN
    .flush_i (bus.flush_i),
`endif
    .wr_i    (bus.wr_i),
    .rd_i    (bus.rd_i),
    .we_o    (we),
    .re_o    (re),
    .wptr_o  (wptr),
    .rptr_o  (rptr),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wptr[ADDR_W-1:0]] <= bus.data_i;
  end

  // Wrap bits only matter inside the pointer controller.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wptr[ADDR_W] ^ rptr[ADDR_W];

  if (SHOW_AHEAD == FIFO_MODE_SHOW_AHEAD) begin : g_show_ahead
    assign bus.data_o = mem_q[rptr[ADDR_W-1:0]];
    logic unused_re;
    assign unused_re = re;
  end else begin : g_registered
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  data_q <= '0;
      else if (re) data_q <= mem_q[rptr[ADDR_W-1:0]];
    end
    assign bus.data_o = data_q;
  end

  assign bus.level_o        = level;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (level >= bus.afull_thr_i);
  assign bus.almost_empty_o = (level <= bus.aempty_thr_i);

  // Sticky errors: a same-cycle set beats err_clr_i. A flush cycle never sets them.
  logic ovf_set, udf_set;
`ifdef FIFO_FLUSH_EN
  assign ovf_set = bus.wr_i & full & ~bus.flush_i;
  assign udf_set = bus.rd_i & empty & ~bus.flush_i;
`else
  assign ovf_set = bus.wr_i & full;
  assign udf_set = bus.rd_i & empty;
`endif

  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~bus.err_clr_i);
    udf_d = udf_set | (udf_q & ~bus.err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a show-ahead and a registered-mode instance (DEPTH=8) share one
// stimulus stream and are compared against a queue-based reference model after every edge.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr = 1'b0, rd = 1'b0, clr = 1'b0, fl = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW:0]   afthr = 4'd6, aethr = 4'd2;

  sync_fifo_prog_if #(.DATA_W(DW), .ADDR_W(AW)) if_sa ();
  sync_fifo_prog_if #(.DATA_W(DW), .ADDR_W(AW)) if_rg ();

  assign if_sa.data_i = din;   assign if_rg.data_i = din;
  assign if_sa.wr_i = wr;      assign if_rg.wr_i = wr;
  assign if_sa.rd_i = rd;      assign if_rg.rd_i = rd;
  assign if_sa.afull_thr_i = afthr;  assign if_rg.afull_thr_i = afthr;
  assign if_sa.aempty_thr_i = aethr; assign if_rg.aempty_thr_i = aethr;
  assign if_sa.err_clr_i = clr;      assign if_rg.err_clr_i = clr;
`ifdef FIFO_FLUSH_EN
  assign if_sa.flush_i = fl;   assign if_rg.flush_i = fl;
`endif

  sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .SHOW_AHEAD(FIFO_MODE_SHOW_AHEAD)) dut_sa (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_sa)
  );

  sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .SHOW_AHEAD(FIFO_MODE_REGISTERED)) dut_rg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rg)
  );

  // Reference model
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0, m_udf = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rdata = '0;
  endtask

  task automatic model_edge();
    int lvl = q.size();
    bit f = (lvl == DEPTH);
    bit e = (lvl == 0);
    if (fl) begin
      q.delete();
      m_ovf = m_ovf && !clr;
      m_udf = m_udf && !clr;
    end else begin
      if (rd && !e) m_rdata = q.pop_front();
      if (wr && !f) q.push_back(din);
      m_ovf = (wr && f) || (m_ovf && !clr);
      m_udf = (rd && e) || (m_udf && !clr);
    end
  endtask

  task automatic check_all();
    int lvl = q.size();
    chk("level_sa", 64'(if_sa.level_o), 64'(lvl));
    chk("level_rg", 64'(if_rg.level_o), 64'(lvl));
    chk("full", 64'(if_sa.full_o), 64'(lvl == DEPTH));
    chk("empty", 64'(if_sa.empty_o), 64'(lvl == 0));
    chk("almost_full", 64'(if_sa.almost_full_o), 64'(lvl >= int'(afthr)));
    chk("almost_empty", 64'(if_sa.almost_empty_o), 64'(lvl <= int'(aethr)));
    chk("overflow", 64'({if_sa.overflow_o, if_rg.overflow_o}), 64'({m_ovf, m_ovf}));
    chk("underflow", 64'({if_sa.underflow_o, if_rg.underflow_o}), 64'({m_udf, m_udf}));
    chk("data_rg", 64'(if_rg.data_o), 64'(m_rdata));
    if (lvl != 0) chk("data_sa", 64'(if_sa.data_o), 64'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic c, input logic f);
    wr = w; rd = r; din = d; clr = c; fl = f;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x10..0x17 then drain, thresholds 6/2 checked at every level
    afthr = 4'd6; aethr = 4'd2;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(16 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Full + write + read: read accepted, write rejected, overflow set, then cleared
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(32 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hdead, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Empty + read + write: write accepted, underflow set; set-with-clear keeps it
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0042, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Registered-mode latency and hold
    step(1'b1, 1'b0, 16'h00a5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h005a, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Wrap: 20 write/read pairs at level 1
    step(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);

`ifdef FIFO_FLUSH_EN
    // Flush at level 5, then a fresh write must come back out
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(16'h0200 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hbeef, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0c0d, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
`endif

    // Randomized traffic with moving thresholds
    for (int i = 0; i < 400; i++) begin
      int unsigned pw = (i / 50) % 2 == 0 ? 70 : 30;
      if (i % 25 == 0) begin
        afthr = AW'(0) + 4'($urandom_range(0, 15));
        aethr = 4'($urandom_range(0, 15));
      end
      step(($urandom % 100) < pw, ($urandom % 100) < (100 - pw), DW'($urandom),
           ($urandom % 16) == 0,
`ifdef FIFO_FLUSH_EN
           ($urandom % 60) == 0
`else
           1'b0
`endif
      );
    end

    // Asynchronous reset mid-burst, then first write lands at the head
    afthr = 4'd6; aethr = 4'd2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0399, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    wr = 1'b0; rd = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0077, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO. Successor to the encoder's fixed half-full FIFO, with the following additions:
- Occupancy count output.
- Runtime-programmable almost-full and almost-empty thresholds.
- Clearable sticky overflow and underflow flags.
- Selectable show-ahead or registered read-data mode.
It buffers compressed bit-plane words between the encoder datapath and the packer/output stage.

Parameters:
DATA_W, 64, data word width in bits.
DEPTH, 32, number of entries; must be a power of 2 and at least 4.
ADDR_W, $clog2(DEPTH), entry index width; derived, never overridden.
SHOW_AHEAD, 1, 1: data_o combinationally shows the head entry. 0: data_o is registered and updated after an accepted read.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
data_i  in  DATA_W  write data.
wr_i  in  1  write request.
rd_i  in  1  read request.
afull_thr_i  in  ADDR_W+1  almost-full threshold, in entries.
aempty_thr_i  in  ADDR_W+1  almost-empty threshold, in entries.
err_clr_i  in  1  clears the sticky error flags.
flush_i  in  1  synchronous flush; port exists only with FIFO_FLUSH_EN.
data_o  out  DATA_W  read data.
level_o  out  ADDR_W+1  occupancy, range 0..DEPTH.
full_o  out  1  level_o == DEPTH.
empty_o  out  1  level_o == 0.
almost_full_o  out  1  level_o >= afull_thr_i.
almost_empty_o  out  1  level_o <= aempty_thr_i.
overflow_o  out  1  sticky: a write was attempted while full.
underflow_o  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset is asynchronous on rst_n low.
  - Pointers, level_o, overflow_o and underflow_o go to 0.
  - data_o goes to 0 in registered mode.
  - Memory contents are not reset.
- Pointers are ADDR_W+1 bits wide. The MSB is the wrap bit; the lower ADDR_W bits index memory. Pointers wrap modulo 2*DEPTH.
- Accepted write: we = wr_i & ~full_o. Accepted read: re = rd_i & ~empty_o. Acceptance is based on the registered state only.
  - A write while full is rejected even if a read occurs in the same cycle.
  - A read while empty is rejected even if a write occurs in the same cycle.
- level_o update per cycle: +1 on we only, -1 on re only, unchanged on both or neither. level_o is registered and consistent with the pointer difference.
- Status outputs are combinational from registered state and the threshold inputs; they take effect in the cycle after the causing edge.
- Full behaviour:
  - A write is accepted at edge N.
  - level_o and the flags reflect the new state after edge N.
  - If the FIFO was at DEPTH-1, full_o is 1 for cycle N+1.
- Thresholds may change at any time; the comparisons are unsigned.
  - afull_thr_i = 0 makes almost_full_o always 1.
  - aempty_thr_i >= DEPTH makes almost_empty_o always 1.
- SHOW_AHEAD=1: data_o = mem[rptr] at all times. The value is undefined while empty; the bench must not check it.
- SHOW_AHEAD=0:
  - On re at edge N, data_o <= mem[rptr] is captured at edge N.
  - data_o holds its value otherwise, including while empty.
  - Read latency is 1 cycle.
- Sticky errors:
  - overflow_o is set at the edge when wr_i & full_o.
  - underflow_o is set at the edge when rd_i & empty_o.
  - err_clr_i clears both flags. If set and clear happen in the same cycle, set wins.
- Simultaneous write and read on a partially filled FIFO: both are accepted and level_o is unchanged.
- If rst_n asserts mid-burst, all state is lost immediately. The first post-reset write goes to entry 0.

Optional Feature:
FIFO_FLUSH_EN
- Defined:
  - flush_i=1 at an edge sets rptr = wptr = 0 and level_o = 0.
  - Flush overrides any we or re in that cycle; the data is dropped and the error flags are not set by it.
  - Sticky flags are untouched.
  - In registered mode, data_o holds its value.
- Undefined: the flush_i port and its logic are absent.

Decomposition:
- Package fifo_pkg holds:
  - the function fifo_addr_w(depth) returning $clog2(depth);
  - localparams for the read-mode encodings FIFO_MODE_SHOW_AHEAD=1 and FIFO_MODE_REGISTERED=0.
- Sub-module fifo_ptr_ctrl (one per FIFO) holds the wptr/rptr/level counters and we/re/flush qualification.
- The top level holds the memory array, the data_o path, the threshold comparators and the sticky flags.

Test Plan:
1. DEPTH=8, SHOW_AHEAD=1: write 0x10..0x17 with no reads → full_o=1 and level_o=8. Then read 8 → data_o sequence 0x10..0x17, ending with empty_o=1.
2. Full, then wr_i=1 with rd_i=1 → read accepted, write rejected, level_o=7, overflow_o=1. Then err_clr_i=1 for one cycle → overflow_o=0.
3. Empty, then rd_i=1 with wr_i=1 → write accepted, level_o=1, underflow_o=1. Same-cycle set plus err_clr_i → flag stays 1.
4. afull_thr_i=6, aempty_thr_i=2: fill 0→8 then drain → almost_full_o=1 exactly for level 6..8, almost_empty_o=1 exactly for level 0..2.
5. SHOW_AHEAD=0: write 0xA5, 0x5A, read twice → data_o=0xA5 the cycle after the first read and 0x5A after the second. data_o holds 0x5A while idle.
6. Wrap: 20 interleaved write/read pairs through DEPTH=8 → data order preserved and level_o stays at 1. With FIFO_FLUSH_EN, flush_i at level 5 → level_o=0, empty_o=1, next write is read back correctly.
